// File: rtl/uart_fifo_pkg.sv
// Shared types and sizing helpers for the UART byte FIFO read/receive paths.
package uart_fifo_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned UART_DATA_DEPTH = 128;

    // Level counter is one bit wider than the pointer so a full FIFO is representable.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [UART_DATA_WIDTH-1:0] byte_t;

endpackage

// File: rtl/uart_skid2.sv
// Two-entry staging buffer; head is always presented, simultaneous push and pop both honoured.
module uart_skid2
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  pop_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop_i & (count_q != 2'd0);
        unique case (count_q)
            2'd0: begin
                if (push_i) begin
                    head_d  = data_in_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop_ok) begin
                    head_d = data_in_i;
                end else if (push_i) begin
                    tail_d  = data_in_i;
                    count_d = 2'd2;
                end else if (pop_ok) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                // A push while full is only legal alongside a pop; the tail then shifts up.
                if (pop_ok) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = data_in_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign data_out_o = head_q;
    assign count_o    = count_q;

    no_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
        (push_i && count_q == 2'd2) |-> pop_i);

endmodule

// File: rtl/uart_fifo_rd_ctrl.sv
// Read-side controller: turns the registered-output byte FIFO into a valid/ready stream,
// tracks FIFO occupancy and raises a level-threshold interrupt.
module uart_fifo_rd_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned DATA_DEPTH = UART_DATA_DEPTH,
    localparam int unsigned LVL_W     = lvl_w(DATA_DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  enable,
    input  logic                  fifo_wr_en,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic [LVL_W-1:0]      thresh,
    output logic [LVL_W-1:0]      level,
    output logic                  thresh_irq,
    output logic                  idle
);

    logic [1:0]       stage_cnt;
    logic             pop;
    logic [2:0]       occupancy;
    logic             wr_acc;
    logic             rd_acc;
    logic             inflight_q, inflight_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             irq_q, irq_d;

    uart_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .push_i     (inflight_q),
        .pop_i      (pop),
        .data_in_i  (fifo_data),
        .data_out_o (m_data),
        .count_o    (stage_cnt)
    );

    // Reads are throttled so staged plus in-flight bytes never exceed the two stage slots;
    // never reading while empty avoids the FIFO's stale read-during-write-when-empty path.
    always_comb begin
        m_valid    = (stage_cnt != 2'd0);
        pop        = m_valid & m_ready;
        occupancy  = {1'b0, stage_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = enable & ~fifo_empty & (occupancy < 3'd2);
        inflight_d = fifo_rd_en;
    end

    // A write while full only lands if a read frees a slot in the same cycle.
    always_comb begin
        wr_acc  = fifo_wr_en & (~fifo_full | fifo_rd_en);
        rd_acc  = fifo_rd_en;
        level_d = level_q;
        if (wr_acc && !rd_acc) begin
            level_d = level_q + 1'b1;
        end else if (!wr_acc && rd_acc) begin
            level_d = level_q - 1'b1;
        end
        irq_d = (thresh != '0) && (level_q >= thresh);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            inflight_q <= 1'b0;
            level_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            level_q    <= level_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        level      = level_q;
        thresh_irq = irq_q;
        idle       = (level_q == '0) && (stage_cnt == 2'd0) && !inflight_q && !fifo_wr_en;
    end

    no_read_empty_a : assert property (@(posedge Clk) disable iff (Reset)
        fifo_empty |-> !fifo_rd_en);

    stream_stable_a : assert property (@(posedge Clk) disable iff (Reset)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule
